// File: rtl/mux_arb_ctrl.sv
// Round-robin arbiter that drives a shared output mux and forwards the owner's valid/ready stream.
// Define MUX_ARB_PKT_LOCK_EN to hold the grant until a beat with last=1 is transferred.
//
// state | meaning
// IDLE  | no owner; outputs forced to 0; waiting for any req_valid
// GRANT | owner's stream routed to the output port
module mux_arb_ctrl #(
    parameter int N_REQ = 4,
    parameter int DATA_W = 8,
    localparam int SEL_W = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]       state;
    logic [SEL_W-1:0] owner;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W:0]   idle_pick;
    logic [SEL_W:0]   next_pick;
    logic             xfer;
    logic             complete;

    // Modulo add that stays correct for non-power-of-two N_REQ.
    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int k);
        int sum;
        sum = (int'(base) + k) % N_REQ;
        return SEL_W'(sum);
    endfunction

    // Returns {found, index} of the first valid requester at start+first_k .. start+N_REQ-1.
    function automatic logic [SEL_W:0] rr_scan(input logic [N_REQ-1:0] valid,
                                               input logic [SEL_W-1:0] start,
                                               input int first_k);
        logic [SEL_W:0]   pick;
        logic [SEL_W-1:0] idx;
        pick = '0;
        for (int k = first_k; k < N_REQ; k++) begin
            idx = wrap_add(start, k);
            if (!pick[SEL_W] && valid[idx]) begin
                pick = {1'b1, idx};
            end
        end
        return pick;
    endfunction

    always_comb begin
        idle_pick = rr_scan(req_valid, ptr, 0);
        next_pick = rr_scan(req_valid, owner, 1);
        xfer      = (state == GRANT) && req_valid[owner] && out_ready;
`ifdef MUX_ARB_PKT_LOCK_EN
        complete  = xfer && req_last[owner];
`else
        complete  = xfer;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (idle_pick[SEL_W]) begin
                        owner <= idle_pick[SEL_W-1:0];
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (complete) begin
                        ptr <= wrap_add(owner, 1);
                        // Handover without a bubble when someone else is waiting.
                        if (next_pick[SEL_W]) begin
                            owner <= next_pick[SEL_W-1:0];
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        req_ready = '0;
        if (state == GRANT) begin
            out_valid        = req_valid[owner];
            out_data         = req_data[owner*DATA_W +: DATA_W];
            out_last         = req_last[owner];
            req_ready[owner] = out_ready;
        end
    end

    assign out_sel = owner;
    assign busy    = (state == GRANT);

endmodule

// File: tb/tb_mux_arb_ctrl.sv
// Self-checking bench for mux_arb_ctrl: rule-level model compared every cycle plus directed literals.
// Works with and without MUX_ARB_PKT_LOCK_EN defined.
module tb_mux_arb_ctrl;

    localparam int N = 4;
    localparam int W = 8;
`ifdef MUX_ARB_PKT_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0] req_last = '0;
    logic [N-1:0] req_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         out_ready = 1'b0;
    logic [1:0]   out_sel;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: who owns the port, whether anyone does, and where the next search starts.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_nx;

    mux_arb_ctrl #(.N_REQ(N), .DATA_W(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .out_sel(out_sel), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // First requester with valid high among start, start+1, ... (count candidates), or -1.
    function automatic int rr_pick(input logic [N-1:0] v, input int start, input int count);
        for (int k = 0; k < count; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0; m_owner = 0; m_ptr = 0;
        end else if (!m_busy) begin
            m_nx = rr_pick(req_valid, m_ptr, N);
            if (m_nx >= 0) begin
                m_owner = m_nx; m_busy = 1'b1;
            end
        end else if (req_valid[m_owner] && out_ready && (!LOCK || req_last[m_owner])) begin
            m_ptr = (m_owner + 1) % N;
            m_nx  = rr_pick(req_valid, (m_owner + 1) % N, N - 1);
            if (m_nx >= 0) m_owner = m_nx;
            else m_busy = 1'b0;
        end
    end

    always @(negedge clk) begin : cmp
        logic [W-1:0] e_data;
        logic         e_valid, e_last;
        logic [N-1:0] e_ready;
        e_valid = 1'b0; e_data = '0; e_last = 1'b0; e_ready = '0;
        if (m_busy) begin
            e_valid          = req_valid[m_owner];
            e_data           = req_data[m_owner*W +: W];
            e_last           = req_last[m_owner];
            e_ready[m_owner] = out_ready;
        end
        chk("m_valid", 32'(out_valid), 32'(e_valid));
        chk("m_data",  32'(out_data),  32'(e_data));
        chk("m_last",  32'(out_last),  32'(e_last));
        chk("m_ready", 32'(req_ready), 32'(e_ready));
        chk("m_sel",   32'(out_sel),   32'(m_owner));
        chk("m_busy",  32'(busy),      32'(m_busy));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [W-1:0] d);
        req_data[i*W +: W] = d;
    endtask

    int fair[6]      = '{0, 1, 2, 3, 0, 1};
    int sole_busy[5] = '{1, 0, 1, 0, 1};
    int pk_exp[4];
    int beat;

    initial begin
        rst = 1'b1;
        pk_exp = LOCK ? '{0, 0, 0, 2} : '{0, 2, 0, 2};

        // Reset held with random inputs
        for (int c = 0; c < 3; c++) begin
            cyc();
            req_valid = N'($urandom_range(0, 15));
            req_data  = $urandom;
            req_last  = N'($urandom_range(0, 15));
            out_ready = 1'($urandom_range(0, 1));
            #1;
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_data",  32'(out_data),  32'd0);
            chk("rst_last",  32'(out_last),  32'd0);
            chk("rst_ready", 32'(req_ready), 32'd0);
            chk("rst_sel",   32'(out_sel),   32'd0);
            chk("rst_busy",  32'(busy),      32'd0);
        end
        req_valid = '0; req_data = '0; req_last = '0; out_ready = 1'b0;
        #2 rst = 1'b0;

        // Per-beat fairness with everyone requesting
        cyc();
        for (int i = 0; i < N; i++) set_lane(i, 8'h10 + 8'(i));
        req_valid = 4'hF; req_last = 4'hF; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc(); #1;
            chk("fair_sel",   32'(out_sel),  32'(fair[k]));
            chk("fair_valid", 32'(out_valid), 32'd1);
            chk("fair_data",  32'(out_data), 32'(8'h10 + 8'(fair[k])));
            if (k == 5) req_valid = 4'b0010;
        end
        cyc(); req_valid = '0; #1;
        chk("fair_idle", 32'(busy), 32'd0);

        // Sole requester: bubble between beats
        cyc();
        beat = 0;
        set_lane(2, 8'h20); req_last = 4'b0100; req_valid = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (sole_busy[k] == 0) begin
                beat++;
                set_lane(2, 8'h20 + 8'(beat));
            end
            #1;
            chk("sole_busy", 32'(busy), 32'(sole_busy[k]));
            if (sole_busy[k] != 0) chk("sole_data", 32'(out_data), 32'(8'h20 + 8'(beat)));
        end
        cyc(); req_valid = '0; #1;
        chk("sole_idle", 32'(busy), 32'd0);

        // Requester 0 packet with requester 2 waiting
        cyc();
        set_lane(0, 8'h40); set_lane(2, 8'h60);
        req_last = 4'b0000; req_valid = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (k == 2) req_last = 4'b0101;
            #1;
            chk("pk_sel",  32'(out_sel),  32'(pk_exp[k]));
            chk("pk_data", 32'(out_data), (pk_exp[k] == 0) ? 32'h40 : 32'h60);
            chk("pk_busy", 32'(busy), 32'd1);
            if (k == 3) req_valid = 4'b0100;
        end
        cyc(); req_valid = '0; #1;
        chk("pk_idle", 32'(busy), 32'd0);

        // Backpressure on owner 1
        cyc();
        set_lane(1, 8'hA5); req_last = 4'b0010; req_valid = 4'b0010; out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc(); #1;
            chk("bp_data",  32'(out_data),  32'hA5);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_sel",   32'(out_sel),   32'd1);
        end
        cyc(); out_ready = 1'b1; #1;
        chk("bp_go", 32'(req_ready), 32'b0010);
        cyc(); req_valid = '0; #1;
        chk("bp_done", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a beat
        cyc();
        set_lane(1, 8'h11); set_lane(3, 8'h33);
        req_last = 4'b1010; req_valid = 4'b1010; out_ready = 1'b1;
        cyc(); #1;
        chk("ar_sel",   32'(out_sel),   32'd3);
        chk("ar_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_rst_valid", 32'(out_valid), 32'd0);
        chk("ar_rst_ready", 32'(req_ready), 32'd0);
        chk("ar_rst_busy",  32'(busy),      32'd0);
        chk("ar_rst_sel",   32'(out_sel),   32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        cyc(); #1;
        chk("ar_regrant_sel",  32'(out_sel), 32'd1);
        chk("ar_regrant_busy", 32'(busy),    32'd1);
        req_valid = '0;
        cyc();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_arb_ctrl.md
# mux_arb_ctrl

Round-robin arbiter and sequencer for a shared combinational output multiplexer. N_REQ requesters present valid/ready streams, and the block grants one owner at a time. It drives the mux select and forwards the owner's data, last flag and handshake to a single downstream port. It sits in front of any shared sink, such as a bus or FIFO write port, that several producers must time-share.

## Interface
- N_REQ, 4: number of requesters, 2..16
- DATA_W, 8: data width per requester
- SEL_W, $clog2(N_REQ): width of out_sel (derived, not overridden)
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester beat valid
- req_data  in  N_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W]
- req_last  in  N_REQ  per-requester end-of-packet flag
- req_ready  out  N_REQ  per-requester accept
- out_valid  out  1  downstream beat valid
- out_data  out  DATA_W  downstream data (muxed)
- out_last  out  1  downstream last flag (muxed)
- out_ready  in  1  downstream accept
- out_sel  out  SEL_W  current owner index (registered)
- busy  out  1  high when state is GRANT

## Operation
- FSM states: IDLE, GRANT. Registers: state, owner (SEL_W), ptr (SEL_W, round-robin start).
- Reset values: state=IDLE, owner=0, ptr=0.
- Reset values of outputs: out_valid=0, out_data=0, out_last=0, req_ready=0, out_sel=0, busy=0.
- IDLE:
  - If any req_valid is high, owner takes the first valid index scanning ptr, ptr+1, ... modulo N_REQ, and the FSM moves to GRANT.
  - Otherwise the FSM stays in IDLE.
- GRANT, combinational path:
  - out_valid = req_valid[owner]
  - out_data = req_data[owner]
  - out_last = req_last[owner]
  - req_ready[owner] = out_ready; all other req_ready are 0.
- IDLE outputs: out_valid, out_data, out_last and all req_ready are forced to 0. Never X.
- A transfer occurs when out_valid && out_ready. The completing transfer is defined by the configuration (see Configuration).
- On a completing transfer:
  - ptr <= owner+1, modulo N_REQ.
  - Next owner is the first valid index scanning owner+1 .. owner+N_REQ-1. The current owner is excluded.
  - If a candidate is found, owner is updated and the FSM stays in GRANT with no bubble.
  - If no candidate is found, the FSM goes to IDLE.
- A non-completing transfer, or no transfer, keeps owner and state.
- Requester rule: once req_valid is asserted, it stays high until accepted. The block does not check this. A withdrawn owner stalls GRANT.
- Index arithmetic wraps modulo N_REQ. This also holds for non-power-of-two N_REQ.

## Timing
- Grant latency: from req_valid rising in IDLE to out_valid is 1 cycle. busy and out_sel update on the same edge.
- Data path owner→out is combinational, zero latency. out_sel and busy are registered.
- Sole owner streaming, no other requests: a completing transfer → IDLE → re-grant, giving a 1-cycle bubble. This is the only bubble case.
- Handover to a different requester: 0 bubble cycles.
- Simultaneous new requests during a completing transfer: they are arbitrated in that same cycle.
- Backpressure with out_ready=0: owner and out_data are held stable, and req_ready stays 0.
- rst asserted at any time: all registers and outputs go to reset values immediately, without waiting for a clock edge. Any in-flight packet is abandoned. Operation resumes on the first rising clk edge after rst deasserts.

## Configuration
- MUX_ARB_PKT_LOCK_EN defined: a completing transfer is a transfer with out_last=1. The grant is held for a whole packet, and non-last beats never re-arbitrate.
- MUX_ARB_PKT_LOCK_EN undefined: every transfer is completing, so arbitration happens per beat. req_last and out_last still pass through but do not affect the FSM.

## Test plan
- Reset check: hold rst=1 with random inputs → all outputs are 0, and busy=0.
- Per-beat fairness, lock undefined: all four req_valid held high, out_ready=1 → out_sel sequence after IDLE is 0,1,2,3,0,1, with one beat each and no bubbles.
- Sole requester, lock undefined: requester 2 sends 3 beats, out_ready=1 → beats appear at cycles 1, 3 and 5 after request. busy toggles 1,0,1,0,1.
- Packet lock, MUX_ARB_PKT_LOCK_EN: requester 0 sends a 3-beat packet (last on beat 3) while requester 2 is waiting from cycle 0 → out_sel=0 for 3 transfers, then 2 on the next cycle with no bubble.
- Backpressure: owner 1 with req_data=0xA5, out_ready=0 for 4 cycles → out_data=0xA5, out_valid=1 and req_ready=0 throughout. The transfer happens on the cycle out_ready=1.
- Asynchronous reset mid-packet: rst pulsed between clock edges during a beat → out_valid and req_ready fall before the next edge. After release, the first grant goes to the lowest valid index starting from 0.
